// File: rtl/bt_axil_regs.sv
// AXI4-Lite register block for the Bluetooth UART: CTRL, BAUD, TXDATA (8-deep TX FIFO), STATUS (RX holding).
// Write/read responses follow acceptance by one cycle; AW/W and AR stall while a response waits on BREADY/RREADY.

module bt_axil_regs_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      // clear takes priority over any pop presented in the same cycle
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module bt_axil_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter int          TX_DEPTH           = 8,
  parameter logic [31:0] BAUD_RESET         = 32'h0000_0364
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [31:0]                     baud_div,
  output logic [7:0]                      tx_data,
  output logic                            tx_valid,
  input  logic                            tx_ready,
  input  logic [7:0]                      rx_data,
  input  logic                            rx_strobe
);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_DATA } r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;
  logic     aw_acc, ar_acc;

  logic [31:0]   ctrl_q, baud_q, wmask, ctrl_wr, rdata_nxt, rdata_q;
  logic [1:0]    bresp_q;
  logic [7:0]    last_q, rx_byte;
  logic          rx_vld, rx_ovr, rx_clr;
  logic [1:0]    wsel, rsel;
  logic          tx_clear, tx_wr, tx_push, tx_drop, tx_pop;
  logic          tx_empty, tx_full;
  logic [CW-1:0] tx_cnt;
  logic          unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // ---------------- write channel ----------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    aw_acc      = 1'b0;
    case (w_state)
      W_IDLE: if (S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID) begin
        aw_acc      = 1'b1;
        w_state_nxt = W_RESP;
      end
      W_RESP: if (S_AXI_BREADY) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign S_AXI_AWREADY = aw_acc;
  assign S_AXI_WREADY  = aw_acc;
  assign S_AXI_BVALID  = (w_state == W_RESP);
  assign S_AXI_BRESP   = bresp_q;

  assign wsel     = S_AXI_AWADDR[3:2];
  assign tx_clear = aw_acc && (wsel == 2'd0) && S_AXI_WSTRB[0] && S_AXI_WDATA[1];
  assign tx_wr    = aw_acc && (wsel == 2'd2) && S_AXI_WSTRB[0];
  assign tx_push  = tx_wr && !tx_full;
  assign tx_drop  = tx_wr && tx_full;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{S_AXI_WSTRB[i]}};
  end

  // tx_clear is a pulse, so bit1 is never stored
  assign ctrl_wr = ((ctrl_q & ~wmask) | (S_AXI_WDATA & wmask)) & ~32'h2;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl_q  <= '0;
      baud_q  <= BAUD_RESET;
      last_q  <= '0;
      bresp_q <= 2'b00;
    end else begin
      if (aw_acc && wsel == 2'd0) ctrl_q <= ctrl_wr;
      if (aw_acc && wsel == 2'd1) baud_q <= (baud_q & ~wmask) | (S_AXI_WDATA & wmask);
      if (tx_push)                last_q <= S_AXI_WDATA[7:0];
      if (aw_acc)                 bresp_q <= tx_drop ? 2'b10 : 2'b00;
    end
  end

  assign baud_div = baud_q;

  // ---------------- TX stream ----------------
  assign tx_valid = ctrl_q[0] & ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;

  bt_axil_regs_fifo #(.DEPTH(TX_DEPTH), .W(8), .CW(CW)) u_tx_fifo (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .clr      (tx_clear),
    .push     (tx_push),
    .push_dat (S_AXI_WDATA[7:0]),
    .pop      (tx_pop),
    .head_dat (tx_data),
    .count    (tx_cnt),
    .empty    (tx_empty),
    .full     (tx_full)
  );

  // ---------------- read channel ----------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    ar_acc      = 1'b0;
    case (r_state)
      R_IDLE: if (S_AXI_ARVALID && !S_AXI_RVALID) begin
        ar_acc      = 1'b1;
        r_state_nxt = R_DATA;
      end
      R_DATA: if (S_AXI_RREADY) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  assign S_AXI_ARREADY = ar_acc;
  assign S_AXI_RVALID  = (r_state == R_DATA);
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = rdata_q;
  assign rsel          = S_AXI_ARADDR[3:2];

  always_comb begin
    rdata_nxt = '0;
    case (rsel)
      2'd0: rdata_nxt = ctrl_q;
      2'd1: rdata_nxt = baud_q;
      2'd2: rdata_nxt = {24'h0, last_q};
      default: rdata_nxt = {8'h0, rx_byte, 6'h0, rx_ovr, rx_vld, 2'h0, 4'(tx_cnt), tx_full, tx_empty};
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)    rdata_q <= '0;
    else if (ar_acc) rdata_q <= rdata_nxt;
  end

  // ---------------- RX holding register ----------------
  assign rx_clr = ar_acc && (rsel == 2'd3);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rx_byte <= '0;
      rx_vld  <= 1'b0;
      rx_ovr  <= 1'b0;
    end else if (rx_strobe) begin
      // a byte arriving during the clearing read survives; only the overrun is dropped
      rx_byte <= rx_data;
      rx_vld  <= 1'b1;
      rx_ovr  <= rx_clr ? 1'b0 : (rx_ovr | rx_vld);
    end else if (rx_clr) begin
      rx_vld <= 1'b0;
      rx_ovr <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bt_axil_regs.sv
// Directed bench for bt_axil_regs; expected B/R/TX responses are queued and checked by negedge monitors.
module tb_bt_axil_regs;
  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [3:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic [31:0] baud_div;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_strobe;

  int checks = 0;
  int failures = 0;
  logic [1:0]  bq[$];
  logic [31:0] rq[$];
  logic [7:0]  txq[$];

  bt_axil_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .baud_div(baud_div), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_strobe(rx_strobe)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge ACLK) begin
    if (ARESETN === 1'b1) begin
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        if (bq.size() == 0) chk("b_unexpected", 1, 0);
        else chk("bresp", {30'h0, S_AXI_BRESP}, {30'h0, bq.pop_front()});
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        if (rq.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          chk("rdata", S_AXI_RDATA, rq.pop_front());
          chk("rresp", {30'h0, S_AXI_RRESP}, 0);
        end
      end
      if (tx_valid && tx_ready) begin
        if (txq.size() == 0) chk("tx_unexpected", 1, 0);
        else chk("tx_data", {24'h0, tx_data}, {24'h0, txq.pop_front()});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step;
    @(posedge ACLK); #1;
  endtask

  task automatic wait_aw;
    bit ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge ACLK);
      ok = S_AXI_AWREADY && S_AXI_WREADY;
    end
    if (!ok) chk("aw_timeout", 0, 1);
    step();
  endtask

  task automatic wait_b;
    bit ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge ACLK);
      ok = S_AXI_BVALID && S_AXI_BREADY;
    end
    if (!ok) chk("b_timeout", 0, 1);
    step();
  endtask

  task automatic wait_ar;
    bit ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge ACLK);
      ok = S_AXI_ARREADY;
    end
    if (!ok) chk("ar_timeout", 0, 1);
    step();
  endtask

  task automatic wait_r;
    bit ok = 0;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge ACLK);
      ok = S_AXI_RVALID && S_AXI_RREADY;
    end
    if (!ok) chk("r_timeout", 0, 1);
    step();
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] exp);
    bq.push_back(exp);
    S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    wait_aw();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    wait_b();
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] exp);
    rq.push_back(exp);
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
    wait_ar();
    S_AXI_ARVALID = 0;
    wait_r();
  endtask

  task automatic rx_pulse(input logic [7:0] v);
    rx_data = v; rx_strobe = 1;
    step();
    rx_strobe = 0;
  endtask

  initial begin
    ARESETN = 0;
    S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 1;
    S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 1;
    tx_ready = 0; rx_data = 0; rx_strobe = 0;

    // reset values
    #12;
    chk("rst_awready", {31'h0, S_AXI_AWREADY}, 0);
    chk("rst_wready",  {31'h0, S_AXI_WREADY}, 0);
    chk("rst_bvalid",  {31'h0, S_AXI_BVALID}, 0);
    chk("rst_arready", {31'h0, S_AXI_ARREADY}, 0);
    chk("rst_rvalid",  {31'h0, S_AXI_RVALID}, 0);
    chk("rst_rdata",   S_AXI_RDATA, 0);
    chk("rst_bresp",   {30'h0, S_AXI_BRESP}, 0);
    chk("rst_baud",    baud_div, 32'h364);
    chk("rst_txvalid", {31'h0, tx_valid}, 0);
    chk("rst_txdata",  {24'h0, tx_data}, 0);
    step();
    ARESETN = 1;
    step();

    axi_read(4'h4, 32'h0000_0364);
    axi_read(4'hC, 32'h0000_0001);

    // basic write/readback
    axi_write(4'h0, 32'h1, 4'hF, 2'b00);
    axi_write(4'h4, 32'h2, 4'hF, 2'b00);
    axi_write(4'h8, 32'h3, 4'hF, 2'b00);
    chk("baud_div_2", baud_div, 32'h2);
    axi_read(4'h0, 32'h1);
    axi_read(4'h4, 32'h2);
    axi_read(4'h8, 32'h3);
    axi_write(4'h0, 32'h3, 4'hF, 2'b00);
    axi_read(4'h0, 32'h1);
    axi_read(4'hC, 32'h1);

    // partial strobe on BAUD: only byte 1 changes
    axi_write(4'h4, 32'hAABB_CCDD, 4'b0010, 2'b00);
    chk("baud_strobe", baud_div, 32'h0000_CC02);
    // TXDATA without WSTRB[0] is ignored
    axi_write(4'h8, 32'h0000_0077, 4'b1110, 2'b00);
    axi_read(4'hC, 32'h1);

    // fill FIFO past full
    for (int i = 0; i < 9; i++)
      axi_write(4'h8, 32'hA0 + i, 4'h1, (i == 8) ? 2'b10 : 2'b00);
    axi_read(4'hC, 32'h22);
    axi_read(4'h8, 32'hA7);
    for (int i = 0; i < 8; i++) txq.push_back(8'hA0 + 8'(i));
    tx_ready = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge ACLK);
      chk("tx_valid_drain", {31'h0, tx_valid}, 1);
    end
    @(negedge ACLK);
    chk("tx_valid_after", {31'h0, tx_valid}, 0);
    step();
    axi_read(4'hC, 32'h1);

    // enable gating and tx_clear
    tx_ready = 0;
    axi_write(4'h0, 32'h0, 4'hF, 2'b00);
    for (int i = 0; i < 3; i++) axi_write(4'h8, 32'hB0 + i, 4'h1, 2'b00);
    tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("tx_valid_disabled", {31'h0, tx_valid}, 0);
    end
    step();
    tx_ready = 0;
    axi_read(4'hC, 32'h0C);
    axi_write(4'h0, 32'h3, 4'hF, 2'b00);
    axi_read(4'h0, 32'h1);
    axi_read(4'hC, 32'h1);
    chk("tx_valid_cleared", {31'h0, tx_valid}, 0);

    // RX holding and overrun
    rx_pulse(8'h55);
    rx_pulse(8'h66);
    axi_read(4'hC, 32'h0066_0301);
    axi_read(4'hC, 32'h0066_0001);
    rx_pulse(8'h88);
    rq.push_back(32'h0088_0101);
    S_AXI_ARADDR = 4'hC; S_AXI_ARVALID = 1;
    rx_data = 8'h77; rx_strobe = 1;
    @(negedge ACLK);
    chk("ar_with_strobe", {31'h0, S_AXI_ARREADY}, 1);
    step();
    S_AXI_ARVALID = 0; rx_strobe = 0;
    wait_r();
    axi_read(4'hC, 32'h0077_0101);
    axi_read(4'hC, 32'h0077_0001);

    // backpressure: B and R stall, no new AW/W while B is pending
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    bq.push_back(2'b00);
    rq.push_back(32'h0000_CC02);
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h1234; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1;
    @(negedge ACLK);
    chk("stall_awready", {31'h0, S_AXI_AWREADY}, 1);
    chk("stall_arready", {31'h0, S_AXI_ARREADY}, 1);
    step();
    S_AXI_ARVALID = 0; S_AXI_WDATA = 32'h5678;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("stall_bvalid", {31'h0, S_AXI_BVALID}, 1);
      chk("stall_rvalid", {31'h0, S_AXI_RVALID}, 1);
      chk("stall_rdata", S_AXI_RDATA, 32'h0000_CC02);
      chk("stall_no_aw", {31'h0, S_AXI_AWREADY}, 0);
    end
    chk("stall_baud", baud_div, 32'h1234);
    step();
    bq.push_back(2'b00);
    S_AXI_BREADY = 1;
    @(negedge ACLK);
    chk("aw_during_bhs", {31'h0, S_AXI_AWREADY}, 0);
    step();
    @(negedge ACLK);
    chk("aw_after_bhs", {31'h0, S_AXI_AWREADY}, 1);
    step();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    wait_b();
    S_AXI_RREADY = 1;
    wait_r();
    chk("baud_5678", baud_div, 32'h5678);

    // reset mid-transaction: no response after release
    S_AXI_BREADY = 0; S_AXI_RREADY = 0;
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h9999; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    S_AXI_ARADDR = 4'h0; S_AXI_ARVALID = 1;
    step();
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
    #2 ARESETN = 0;
    #1;
    chk("mid_rst_bvalid", {31'h0, S_AXI_BVALID}, 0);
    chk("mid_rst_rvalid", {31'h0, S_AXI_RVALID}, 0);
    chk("mid_rst_baud", baud_div, 32'h364);
    step();
    ARESETN = 1;
    S_AXI_BREADY = 1; S_AXI_RREADY = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk("post_rst_bvalid", {31'h0, S_AXI_BVALID}, 0);
      chk("post_rst_rvalid", {31'h0, S_AXI_RVALID}, 0);
    end
    step();
    axi_read(4'h4, 32'h364);

    repeat (3) step();
    chk("bq_drained",  bq.size(), 0);
    chk("rq_drained",  rq.size(), 0);
    chk("txq_drained", txq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
